uart_rx_path_cfg: RTL and testbench

UART_RX_PATH_CFG -- requirements
Module: uart_rx_path_cfg

---
 rtl/uart_rx_path_cfg.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_rx_path_cfg.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_path_cfg.sv
// uart_rx_path_cfg: configurable UART receive path with RX FIFO.
//   Oversampled (16x via sample_tick) receiver for 5..8 data bits, optional
//   even/odd parity and one or two stop bits, feeding a first-word-fall-through
//   FIFO that stores {ferr, perr, data} per frame.
// Ports:
//   uart_clk, rst_n          sole clock, async active-low reset
//   sample_tick              16x oversample enable (one uart_clk wide)
//   rx_serial                async serial line, idles high
//   cfg_data_bits/parity/stop2  frame format, latched at start-bit detection
//   cfg_thresh               FIFO level threshold for thresh_irq (0 = off)
//   rd_en, rd_data/perr/ferr FIFO head (FWFT) and pop strobe
//   rx_empty/full/level      FIFO status; rx_active = receiver not idle
//   frame/parity/overrun_error  sticky errors, cleared by err_clr[0/1/2]
//   thresh_irq, timeout_irq  level-sensitive interrupts
//   o_dbg_state              current receiver FSM state
// Handshake: the receiver offers one push per completed frame; it is accepted
// when the FIFO is not full or rd_en pops in the same cycle, otherwise the
// byte is dropped. rd_en pops the head only when the FIFO is non-empty.
module uart_rx_path_cfg #(
    parameter int FIFO_DEPTH   = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                          uart_clk,
    input  logic                          rst_n,
    input  logic                          sample_tick,
    input  logic                          rx_serial,
    input  logic [1:0]                    cfg_data_bits,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    input  logic [$clog2(FIFO_DEPTH):0]   cfg_thresh,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rx_active,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic                          overrun_error,
    input  logic [2:0]                    err_clr,
    output logic                          thresh_irq,
    output logic                          timeout_irq,
    output logic [2:0]                    o_dbg_state
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam int TO_MAX = TIMEOUT_BITS * 16;
    localparam int TW     = $clog2(TO_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Input synchronizer, reset to idle-high so reset never looks like a start bit
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx;

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], rx_serial};
    end
    assign w_rx = r_sync[SYNC_STAGES-1];

    // Receiver FSM
    logic [2:0] r_state;
    logic       r_armed;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic       r_stop_cnt;
    logic [7:0] r_shift;
    logic       r_perr, r_ferr, r_push;
    logic [1:0] r_cfg_bits;
    logic       r_cfg_par_en, r_cfg_odd, r_cfg_stop2;
    logic       w_mid;
    logic [2:0] w_last_bit;
    logic       w_ferr_now;

    // Tick counter wraps 15->0, so every 16th tick after entering a bit lands mid-bit
    assign w_mid      = (r_tick_cnt == 4'hF);
    assign w_last_bit = {1'b0, r_cfg_bits} + 3'd4;
    assign w_ferr_now = r_ferr | ~w_rx;

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b1;
            r_tick_cnt   <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= 8'd0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_push       <= 1'b0;
            r_cfg_bits   <= 2'd0;
            r_cfg_par_en <= 1'b0;
            r_cfg_odd    <= 1'b0;
            r_cfg_stop2  <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (sample_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_rx) begin
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_state      <= S_START;
                            r_tick_cnt   <= 4'd0;
                            r_bit_cnt    <= 3'd0;
                            r_stop_cnt   <= 1'b0;
                            r_shift      <= 8'd0;
                            r_perr       <= 1'b0;
                            r_ferr       <= 1'b0;
                            r_cfg_bits   <= cfg_data_bits;
                            r_cfg_par_en <= cfg_parity_en;
                            r_cfg_odd    <= cfg_parity_odd;
                            r_cfg_stop2  <= cfg_stop2;
                        end
                    end
                    S_START: begin
                        // Detection tick was tick 0; re-check the line at tick 8
                        if (r_tick_cnt == 4'd7) begin
                            r_tick_cnt <= 4'd0;
                            r_state    <= w_rx ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                    S_DATA: begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_mid) begin
                            r_shift[r_bit_cnt] <= w_rx;
                            r_bit_cnt          <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == w_last_bit)
                                r_state <= r_cfg_par_en ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_mid) begin
                            // Unused upper data bits are 0 so they do not affect the XOR
                            r_perr  <= ((^r_shift) ^ w_rx) != r_cfg_odd;
                            r_state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_mid) begin
                            r_ferr <= w_ferr_now;
                            if (r_cfg_stop2 && !r_stop_cnt) begin
                                r_stop_cnt <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_push  <= 1'b1;
                                // A held-low line after a bad stop must not start a new frame
                                r_armed <= ~w_ferr_now;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_active   = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    // RX FIFO
    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_rd, w_push_ok;
    logic [9:0]    w_head;

    assign rx_empty  = (r_level == LW'(0));
    assign rx_full   = (r_level == LW'(FIFO_DEPTH));
    assign rx_level  = r_level;
    assign w_rd      = rd_en && !rx_empty;
    assign w_push_ok = r_push && (!rx_full || rd_en);

    always_ff @(posedge uart_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {r_ferr, r_perr, r_shift};
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd)      r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_head  = r_mem[r_rd_ptr];
    assign rd_data = w_head[7:0];
    assign rd_perr = w_head[8];
    assign rd_ferr = w_head[9];

    // Sticky errors: a set in the same cycle as its clear wins
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (r_push && r_ferr)          frame_error   <= 1'b1;
            else if (err_clr[0])           frame_error   <= 1'b0;
            if (r_push && r_perr)          parity_error  <= 1'b1;
            else if (err_clr[1])           parity_error  <= 1'b0;
            if (r_push && !w_push_ok)      overrun_error <= 1'b1;
            else if (err_clr[2])           overrun_error <= 1'b0;
        end
    end

    assign thresh_irq = (cfg_thresh != '0) && (r_level >= cfg_thresh);

    // Idle timeout: counts ticks while data waits in the FIFO and the line is quiet
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_push || w_rd || rx_active || rx_empty) begin
            r_to_cnt <= '0;
        end else if (sample_tick && (r_to_cnt != TW'(TO_MAX))) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign timeout_irq = (r_to_cnt == TW'(TO_MAX));

endmodule

// File: tb/tb_uart_rx_path_cfg.sv
// tb_uart_rx_path_cfg: directed bench for uart_rx_path_cfg (default parameters).
// sample_tick pulses every 4th uart_clk; one bit time is 16 ticks.
`timescale 1ns/1ps
module tb_uart_rx_path_cfg;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          uart_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_tick = 1'b0;
    logic          rx_serial = 1'b1;
    logic [1:0]    cfg_data_bits = 2'b11;
    logic          cfg_parity_en = 1'b0;
    logic          cfg_parity_odd = 1'b0;
    logic          cfg_stop2 = 1'b0;
    logic [LW-1:0] cfg_thresh = '0;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_perr, rd_ferr;
    logic          rx_empty, rx_full;
    logic [LW-1:0] rx_level;
    logic          rx_active;
    logic          frame_error, parity_error, overrun_error;
    logic [2:0]    err_clr = 3'b000;
    logic          thresh_irq, timeout_irq;
    logic [2:0]    dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [1:0] tick_div = 2'd0;

    uart_rx_path_cfg #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_BITS(40)) dut (
        .uart_clk(uart_clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .rx_serial(rx_serial), .cfg_data_bits(cfg_data_bits),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2(cfg_stop2), .cfg_thresh(cfg_thresh), .rd_en(rd_en),
        .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
        .rx_empty(rx_empty), .rx_full(rx_full), .rx_level(rx_level),
        .rx_active(rx_active), .frame_error(frame_error),
        .parity_error(parity_error), .overrun_error(overrun_error),
        .err_clr(err_clr), .thresh_irq(thresh_irq), .timeout_irq(timeout_irq),
        .o_dbg_state(dbg_state)
    );

    // Clock and oversample tick
    always #5 uart_clk = ~uart_clk;

    initial begin
        forever begin
            @(negedge uart_clk);
            tick_div    = tick_div + 2'd1;
            sample_tick = (tick_div == 2'd0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the posedge that consumed the n-th tick
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge uart_clk); while (!sample_tick);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        wait_ticks(16);
    endtask

    // Leaves the line at the final stop value
    task automatic send_frame(input logic [7:0] d, input int nb, input logic par_en,
                              input logic par_val, input int nstop, input logic stop_val);
        wait_ticks(4);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (par_en) send_bit(par_val);
        for (int i = 0; i < nstop; i++) send_bit(stop_val);
    endtask

    task automatic rd_pulse();
        rd_en = 1'b1;
        @(posedge uart_clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic clr_err(input logic [2:0] v);
        err_clr = v;
        @(posedge uart_clk);
        #1;
        err_clr = 3'b000;
    endtask

    task automatic set_cfg(input logic [1:0] bits, input logic pen, input logic podd, input logic s2);
        cfg_data_bits  = bits;
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = s2;
    endtask

    // Directed sequence
    initial begin
        repeat (3) @(posedge uart_clk);
        #1;
        check("rst_empty", rx_empty, 1);
        check("rst_full", rx_full, 0);
        check("rst_level", rx_level, 0);
        check("rst_active", rx_active, 0);
        check("rst_errs", {frame_error, parity_error, overrun_error}, 0);
        check("rst_irqs", {thresh_irq, timeout_irq}, 0);
        rst_n = 1'b1;
        wait_ticks(2);

        // 8N1 0xA5
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
        check("a5_level", rx_level, 1);
        check("a5_data", rd_data, 8'hA5);
        check("a5_flags", {rd_perr, rd_ferr}, 2'b00);
        check("a5_errs", {frame_error, parity_error, overrun_error}, 0);
        check("a5_active", rx_active, 0);
        rd_pulse();
        check("a5_rd_empty", rx_empty, 1);
        rd_pulse();
        check("rd_on_empty_level", rx_level, 0);

        // 7E1 0x35 with wrong parity bit (4 ones -> correct bit is 0)
        set_cfg(2'b10, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1, 1'b1);
        check("par_data", rd_data, 8'h35);
        check("par_rd_perr", rd_perr, 1);
        check("par_rd_ferr", rd_ferr, 0);
        check("par_sticky", parity_error, 1);
        check("par_no_ferr", frame_error, 0);
        clr_err(3'b010);
        check("par_clr", parity_error, 0);
        rd_pulse();

        // 6O2 0x2A (3 ones -> odd parity bit 0 is correct)
        set_cfg(2'b01, 1'b1, 1'b1, 1'b1);
        send_frame(8'h2A, 6, 1'b1, 1'b0, 2, 1'b1);
        check("6o2_data", rd_data, 8'h2A);
        check("6o2_flags", {rd_perr, rd_ferr}, 2'b00);
        rd_pulse();

        // 5N1 with upper driven bits ignored: 0xF3 -> 0x13
        set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF3, 5, 1'b0, 1'b0, 1, 1'b1);
        check("5n1_data", rd_data, 8'h13);
        rd_pulse();
        check("5n1_empty", rx_empty, 1);

        // Glitch: 4 ticks low on idle line
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        wait_ticks(4);
        rx_serial = 1'b0;
        wait_ticks(2);
        check("glitch_active", rx_active, 1);
        wait_ticks(2);
        rx_serial = 1'b1;
        wait_ticks(5);
        check("glitch_idle_by_tick8", rx_active, 0);
        wait_ticks(20);
        check("glitch_no_push", rx_level, 0);
        check("glitch_no_err", {frame_error, parity_error, overrun_error}, 0);

        // Bad stop bit, then line held low for 3 frame times
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b0);
        wait_ticks(480);
        check("brk_level", rx_level, 1);
        check("brk_data", rd_data, 8'h5A);
        check("brk_rd_ferr", rd_ferr, 1);
        check("brk_sticky", frame_error, 1);
        check("brk_disarmed", rx_active, 0);
        rx_serial = 1'b1;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1);
        check("brk_rearm_level", rx_level, 2);
        clr_err(3'b001);
        check("brk_clr", frame_error, 0);
        rd_pulse();
        check("brk_next_data", rd_data, 8'h3C);
        check("brk_next_ferr", rd_ferr, 0);
        rd_pulse();

        // 17 bytes without reads
        cfg_thresh = 5'd4;
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 8, 1'b0, 1'b0, 1, 1'b1);
        check("ovr_level", rx_level, DEPTH);
        check("ovr_full", rx_full, 1);
        check("ovr_sticky", overrun_error, 1);
        check("ovr_head", rd_data, 8'h10);
        for (int i = 0; i < DEPTH; i++) begin
            check("ovr_drain_data", rd_data, 8'h10 + 8'(i));
            check("ovr_thresh", thresh_irq, (DEPTH - i) >= 4);
            rd_pulse();
        end
        check("ovr_drained", rx_empty, 1);
        check("ovr_thresh_empty", thresh_irq, 0);
        clr_err(3'b100);
        check("ovr_clr", overrun_error, 0);
        cfg_thresh = '0;

        // Timeout: push lands at tick 9 of the stop bit, so 7 ticks have already
        // been counted when send_frame returns.
        send_frame(8'h77, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_ticks(632);
        check("to_before", timeout_irq, 0);
        wait_ticks(1);
        check("to_at_640", timeout_irq, 1);
        wait_ticks(5);
        check("to_hold", timeout_irq, 1);
        rd_pulse();
        check("to_rd_clear", timeout_irq, 0);
        check("to_rd_empty", rx_level, 0);

        // Reset mid-frame
        wait_ticks(4);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        @(posedge uart_clk);
        #1;
        check("mid_rst_active", rx_active, 0);
        rst_n = 1'b1;
        rx_serial = 1'b1;
        wait_ticks(200);
        check("mid_rst_level", rx_level, 0);
        check("mid_rst_errs", {frame_error, parity_error, overrun_error}, 0);
        check("mid_rst_idle", rx_active, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
